vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port 128 KB VRAM (32-bit words) between four requesters: the host data-port interface, the layer 0 renderer, the layer 1 renderer and the sprite renderer. One access is granted per clock using rotating round-robin priority, or fixed host-first priority when configured. The block sits between the register interface / render engines and the synchronous VRAM macro. It translates byte-wide host accesses into word accesses with byte enables, and routes read data back to the requester that issued the access.

## Interface
- HOST_PRIORITY, 0, 0: round-robin across all four requesters; 1: host always wins, round-robin among the other three
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- host_addr  in  17  VRAM byte address
- host_wrdata  in  8  write byte
- host_write  in  1  1 = write, 0 = read
- host_req  in  1  access request
- host_ack  out  1  request accepted this cycle
- host_rddata  out  8  read byte
- host_rddata_valid  out  1  host_rddata valid
- l0_addr / l1_addr / spr_addr  in  15  word address (read-only requesters)
- l0_req / l1_req / spr_req  in  1  read request
- l0_ack / l1_ack / spr_ack  out  1  request accepted
- l0_rddata / l1_rddata / spr_rddata  out  32  read word
- l0_rddata_valid / l1_rddata_valid / spr_rddata_valid  out  1  read word valid
- vram_addr  out  15  word address
- vram_wrdata  out  32  write data
- vram_wrbytesel  out  4  byte write enables
- vram_write  out  1  write strobe
- vram_rddata  in  32  read data, valid the cycle after address

## Operation
- Requester indices: host = 0, l0 = 1, l1 = 2, spr = 3.
- Grant is combinational from the req lines and the registered 2-bit pointer `ptr`. The winner is the first asserted req scanning ptr, ptr+1, … mod 4.
- When HOST_PRIORITY=1, host_req overrides the scan.
- Exactly one ack is high per cycle, and only if some req is high. ack = grant.
- After a grant to index i, ptr ← (i+1) mod 4. With no grant, ptr holds. Host grants under HOST_PRIORITY=1 leave ptr unchanged.
- Address mux: vram_addr = host_addr[16:2] for host, otherwise the winner's word address. With no grant, vram_addr holds the last value and vram_write = 0.
- Host write:
  - vram_write = 1
  - vram_wrbytesel = 1 << host_addr[1:0]
  - vram_wrdata = {4{host_wrdata}}
  - no rddata_valid follows
- Reads: vram_write = 0 and vram_wrbytesel = 0.
- Read routing: the grant index and host_addr[1:0] are registered.
  - Next cycle, the matching *_rddata_valid is 1 and *_rddata = vram_rddata.
  - host_rddata = vram_rddata byte selected by the registered addr[1:0] (0 → [7:0], 3 → [31:24]).
- Requesters hold addr/data stable while req is high. Dropping req before ack is legal; no access occurs.
- Reset (rst=1):
  - ptr = 0
  - all acks = 0, vram_write = 0, vram_wrbytesel = 0
  - all *_rddata_valid = 0, vram_addr = 0
  - a read granted in the cycle before rst loses its rddata_valid, and the requester must re-request
  - req inputs are ignored during reset

## Timing
- Accept latency is 0: ack in the same cycle as req when that requester wins.
- Read data latency is 1: *_rddata_valid is high for exactly one cycle, the cycle after ack.
- Throughput is one access per clock. Back-to-back grants to the same requester are allowed when it is the only requester.
- Worst-case wait under round-robin is 3 cycles with all four requesting continuously.
- Host write then read of the same word on consecutive grants returns the written byte; VRAM is write-first.

## Structure
- Package vram_arb_pkg holds:
  - localparams NUM_REQ = 4
  - REQ_HOST = 0, REQ_L0 = 1, REQ_L1 = 2, REQ_SPR = 3
  - VRAM_WORD_AW = 15
- Sub-module rr_picker: purely combinational; inputs req[3:0] and ptr[1:0]; outputs a one-hot grant[3:0] and a valid flag.
- Pointer register, address/write mux and read-return registers live in vram_arbiter.

## Test plan
- **Host write.** Host write 0xA5 at 0x00002 → same cycle:
  - host_ack=1, vram_addr=0x0000, vram_wrbytesel=4'b0100, vram_wrdata=0xA5A5A5A5, vram_write=1
  - no host_rddata_valid next cycle.
- **Host read.** Host read at 0x00007 with VRAM word 1 = 0x425AA500 → host_ack same cycle; next cycle host_rddata_valid=1, host_rddata=0x42.
- **Round-robin order.** All four reqs held high from reset release → acks host, l0, l1, spr, host, l0… one per cycle; each *_rddata_valid follows its ack by one cycle.
- **Host priority.** HOST_PRIORITY=1, l0 and spr held high, host_req pulsed every 3rd cycle → host acked on every host_req cycle; l0 and spr alternate otherwise.
- **Reset mid-read.** l1 read acked, rst=1 the next cycle → l1_rddata_valid=0 and ptr=0. After release with all reqs high, host is granted first.
- **Abandoned request.** l0_req high for one cycle while host wins, then dropped → no l0_ack, no l0_rddata_valid, and ptr advances to 1 only from the host grant.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned REQ_IDX_W    = 2;
  localparam int unsigned REQ_HOST     = 0;
  localparam int unsigned REQ_L0       = 1;
  localparam int unsigned REQ_L1       = 2;
  localparam int unsigned REQ_SPR      = 3;
  localparam int unsigned VRAM_WORD_AW = 15;
  localparam int unsigned VRAM_DW      = 32;
  localparam int unsigned HOST_AW      = 17;
  localparam int unsigned HOST_DW      = 8;
  localparam int unsigned BYTE_SEL_W   = 2;

  // Read-return state captured at grant time, consumed one cycle later
  typedef struct packed {
    logic [NUM_REQ-1:0]    valid;
    logic [BYTE_SEL_W-1:0] byte_sel;
  } rd_ret_t;

  function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (oh[k]) idx = REQ_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first asserted req from ptr upward, mod 4.
module rr_picker
  import vram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [REQ_IDX_W-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_grant_c,
  output logic                 o_valid_c
);

  logic [REQ_IDX_W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest asserted req is written last
  always_comb begin
    o_grant_c = '0;
    o_valid_c = |i_req;
    w_idx     = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = i_ptr + REQ_IDX_W'(k);
      if (i_req[w_idx]) o_grant_c = NUM_REQ'(1) << w_idx;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Four-way VRAM arbiter: grants one access per clock and routes read data back.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [HOST_AW-1:0]      i_host_addr,
  input  logic [HOST_DW-1:0]      i_host_wrdata,
  input  logic                    i_host_write,
  input  logic                    i_host_req,
  output logic                    o_host_ack,
  output logic [HOST_DW-1:0]      o_host_rddata,
  output logic                    o_host_rddata_valid,
  input  logic [VRAM_WORD_AW-1:0] i_l0_addr,
  input  logic                    i_l0_req,
  output logic                    o_l0_ack,
  output logic [VRAM_DW-1:0]      o_l0_rddata,
  output logic                    o_l0_rddata_valid,
  input  logic [VRAM_WORD_AW-1:0] i_l1_addr,
  input  logic                    i_l1_req,
  output logic                    o_l1_ack,
  output logic [VRAM_DW-1:0]      o_l1_rddata,
  output logic                    o_l1_rddata_valid,
  input  logic [VRAM_WORD_AW-1:0] i_spr_addr,
  input  logic                    i_spr_req,
  output logic                    o_spr_ack,
  output logic [VRAM_DW-1:0]      o_spr_rddata,
  output logic                    o_spr_rddata_valid,
  output logic [VRAM_WORD_AW-1:0] o_vram_addr,
  output logic [VRAM_DW-1:0]      o_vram_wrdata,
  output logic [3:0]              o_vram_wrbytesel,
  output logic                    o_vram_write,
  input  logic [VRAM_DW-1:0]      i_vram_rddata
);

  logic [REQ_IDX_W-1:0]    r_ptr;
  logic [VRAM_WORD_AW-1:0] r_last_addr;
  rd_ret_t                 r_rd_ret;

  logic [NUM_REQ-1:0]      w_req;
  logic [NUM_REQ-1:0]      w_scan_req;
  logic [NUM_REQ-1:0]      w_rr_grant;
  logic                    w_rr_valid;
  logic                    w_host_force;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_any;
  logic                    w_host_wr;
  logic [VRAM_WORD_AW-1:0] w_addr;
  logic [NUM_REQ-1:0]      w_rd_valid;

  // Requests are ignored while reset is held
  assign w_req        = {i_spr_req, i_l1_req, i_l0_req, i_host_req} & {NUM_REQ{~i_rst}};
  assign w_host_force = HOST_PRIORITY && w_req[REQ_HOST];
  assign w_scan_req   = HOST_PRIORITY ? (w_req & ~(NUM_REQ'(1) << REQ_HOST)) : w_req;

  rr_picker u_picker (
    .i_req     (w_scan_req),
    .i_ptr     (r_ptr),
    .o_grant_c (w_rr_grant),
    .o_valid_c (w_rr_valid)
  );

  assign w_grant   = w_host_force ? (NUM_REQ'(1) << REQ_HOST) : w_rr_grant;
  assign w_any     = w_host_force | w_rr_valid;
  assign w_host_wr = w_grant[REQ_HOST] & i_host_write;

  always_comb begin
    w_addr = r_last_addr;
    if (w_grant[REQ_HOST])     w_addr = i_host_addr[HOST_AW-1:BYTE_SEL_W];
    else if (w_grant[REQ_L0])  w_addr = i_l0_addr;
    else if (w_grant[REQ_L1])  w_addr = i_l1_addr;
    else if (w_grant[REQ_SPR]) w_addr = i_spr_addr;
  end

  // Forced host grants do not disturb the rotation among the renderers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_last_addr <= '0;
      r_rd_ret    <= '0;
    end else begin
      if (w_any && !w_host_force) r_ptr <= onehot_to_idx(w_grant) + REQ_IDX_W'(1);
      r_last_addr       <= w_addr;
      r_rd_ret.valid    <= w_grant & ~(NUM_REQ'(w_host_wr) << REQ_HOST);
      r_rd_ret.byte_sel <= i_host_addr[BYTE_SEL_W-1:0];
    end
  end

  assign o_host_ack = w_grant[REQ_HOST];
  assign o_l0_ack   = w_grant[REQ_L0];
  assign o_l1_ack   = w_grant[REQ_L1];
  assign o_spr_ack  = w_grant[REQ_SPR];

  assign o_vram_addr      = i_rst ? '0 : w_addr;
  assign o_vram_write     = w_host_wr;
  assign o_vram_wrbytesel = w_host_wr ? (4'(1) << i_host_addr[BYTE_SEL_W-1:0]) : 4'(0);
  assign o_vram_wrdata    = {4{i_host_wrdata}};

  // A read granted just before reset must not report its data
  assign w_rd_valid = r_rd_ret.valid & {NUM_REQ{~i_rst}};

  assign o_host_rddata_valid = w_rd_valid[REQ_HOST];
  assign o_l0_rddata_valid   = w_rd_valid[REQ_L0];
  assign o_l1_rddata_valid   = w_rd_valid[REQ_L1];
  assign o_spr_rddata_valid  = w_rd_valid[REQ_SPR];

  assign o_host_rddata = HOST_DW'(i_vram_rddata >> {r_rd_ret.byte_sel, 3'b000});
  assign o_l0_rddata   = i_vram_rddata;
  assign o_l1_rddata   = i_vram_rddata;
  assign o_spr_rddata  = i_vram_rddata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: round-robin and host-priority instances.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [16:0] host_addr;
  logic [7:0]  host_wrdata;
  logic        host_write, host_req;
  logic [14:0] l0_addr, l1_addr, spr_addr;
  logic        l0_req, l1_req, spr_req;

  logic        host_ack, host_rddata_valid, l0_ack, l0_rddata_valid;
  logic        l1_ack, l1_rddata_valid, spr_ack, spr_rddata_valid, vram_write;
  logic [7:0]  host_rddata;
  logic [31:0] l0_rddata, l1_rddata, spr_rddata, vram_wrdata, vram_rddata;
  logic [14:0] vram_addr;
  logic [3:0]  vram_wrbytesel;

  logic        hp_host_ack, hp_host_rddata_valid, hp_l0_ack, hp_l0_rddata_valid;
  logic        hp_l1_ack, hp_l1_rddata_valid, hp_spr_ack, hp_spr_rddata_valid, hp_vram_write;
  logic [7:0]  hp_host_rddata;
  logic [31:0] hp_l0_rddata, hp_l1_rddata, hp_spr_rddata, hp_vram_wrdata;
  logic [31:0] hp_vram_rddata = 32'h0;
  logic [14:0] hp_vram_addr;
  logic [3:0]  hp_vram_wrbytesel;

  vram_arbiter #(.HOST_PRIORITY(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_addr(host_addr), .i_host_wrdata(host_wrdata), .i_host_write(host_write),
    .i_host_req(host_req), .o_host_ack(host_ack), .o_host_rddata(host_rddata),
    .o_host_rddata_valid(host_rddata_valid),
    .i_l0_addr(l0_addr), .i_l0_req(l0_req), .o_l0_ack(l0_ack), .o_l0_rddata(l0_rddata),
    .o_l0_rddata_valid(l0_rddata_valid),
    .i_l1_addr(l1_addr), .i_l1_req(l1_req), .o_l1_ack(l1_ack), .o_l1_rddata(l1_rddata),
    .o_l1_rddata_valid(l1_rddata_valid),
    .i_spr_addr(spr_addr), .i_spr_req(spr_req), .o_spr_ack(spr_ack), .o_spr_rddata(spr_rddata),
    .o_spr_rddata_valid(spr_rddata_valid),
    .o_vram_addr(vram_addr), .o_vram_wrdata(vram_wrdata), .o_vram_wrbytesel(vram_wrbytesel),
    .o_vram_write(vram_write), .i_vram_rddata(vram_rddata)
  );

  vram_arbiter #(.HOST_PRIORITY(1'b1)) dut_hp (
    .i_clk(clk), .i_rst(rst),
    .i_host_addr(host_addr), .i_host_wrdata(host_wrdata), .i_host_write(host_write),
    .i_host_req(host_req), .o_host_ack(hp_host_ack), .o_host_rddata(hp_host_rddata),
    .o_host_rddata_valid(hp_host_rddata_valid),
    .i_l0_addr(l0_addr), .i_l0_req(l0_req), .o_l0_ack(hp_l0_ack), .o_l0_rddata(hp_l0_rddata),
    .o_l0_rddata_valid(hp_l0_rddata_valid),
    .i_l1_addr(l1_addr), .i_l1_req(l1_req), .o_l1_ack(hp_l1_ack), .o_l1_rddata(hp_l1_rddata),
    .o_l1_rddata_valid(hp_l1_rddata_valid),
    .i_spr_addr(spr_addr), .i_spr_req(spr_req), .o_spr_ack(hp_spr_ack),
    .o_spr_rddata(hp_spr_rddata), .o_spr_rddata_valid(hp_spr_rddata_valid),
    .o_vram_addr(hp_vram_addr), .o_vram_wrdata(hp_vram_wrdata),
    .o_vram_wrbytesel(hp_vram_wrbytesel), .o_vram_write(hp_vram_write),
    .i_vram_rddata(hp_vram_rddata)
  );

  // Write-first synchronous VRAM macro model
  logic [31:0] mem [32768];
  logic [31:0] mem_w;
  always @(posedge clk) begin
    mem_w = mem[vram_addr];
    if (vram_write)
      for (int b = 0; b < 4; b++) if (vram_wrbytesel[b]) mem_w[8*b +: 8] = vram_wrdata[8*b +: 8];
    mem[vram_addr] <= mem_w;
    vram_rddata    <= mem_w;
  end

  typedef struct { int idx; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input int idx);
    case (idx)
      0:       return {24'h0, host_rddata};
      1:       return l0_rddata;
      2:       return l1_rddata;
      default: return spr_rddata;
    endcase
  endfunction

  // One cycle on the round-robin instance; idx = expected winner, -1 = none
  task automatic step(input int idx);
    logic [3:0]  acks, vals, exp_vals;
    logic [14:0] exp_addr;
    logic [31:0] w;
    logic        hw;
    exp_t        e;
    #4;
    acks = {spr_ack, l1_ack, l0_ack, host_ack};
    vals = {spr_rddata_valid, l1_rddata_valid, l0_rddata_valid, host_rddata_valid};
    if (rst) begin
      sb.delete();
      chk("rst_valid", 32'(vals), 32'h0);
      chk("rst_ack", 32'(acks), 32'h0);
      chk("rst_addr", 32'(vram_addr), 32'h0);
      chk("rst_wr", 32'({vram_write, vram_wrbytesel}), 32'h0);
    end else begin
      exp_vals = 4'h0;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        exp_vals = 4'(1) << e.idx;
      end
      chk("rd_valid", 32'(vals), 32'(exp_vals));
      if (exp_vals != 4'h0) chk("rd_data", rd_of(e.idx), e.data);
      chk("ack", 32'(acks), (idx < 0) ? 32'h0 : 32'(1) << idx);
      case (idx)
        0:       exp_addr = host_addr[16:2];
        1:       exp_addr = l0_addr;
        2:       exp_addr = l1_addr;
        3:       exp_addr = spr_addr;
        default: exp_addr = vram_addr_hold;
      endcase
      chk("vram_addr", 32'(vram_addr), 32'(exp_addr));
      vram_addr_hold = exp_addr;
      hw = (idx == 0) && host_write;
      chk("vram_write", 32'(vram_write), 32'(hw));
      chk("wrbytesel", 32'(vram_wrbytesel), hw ? 32'(1) << host_addr[1:0] : 32'h0);
      if (hw) chk("wrdata", vram_wrdata, {4{host_wrdata}});
      else if (idx >= 0) begin
        w = mem[exp_addr];
        e.idx  = idx;
        e.data = (idx == 0) ? 32'(w >> {host_addr[1:0], 3'b000}) & 32'hFF : w;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  logic [14:0] vram_addr_hold = 15'h0;

  task automatic set_reqs(input logic h, input logic a, input logic b, input logic s);
    host_req = h; l0_req = a; l1_req = b; spr_req = s;
  endtask

  initial begin
    int exp_hp, prev_hp;
    rst = 1'b1; host_addr = 17'h00007; host_wrdata = 8'h00; host_write = 1'b0;
    l0_addr = 15'h0010; l1_addr = 15'h0020; spr_addr = 15'h0030;
    set_reqs(1'b1, 1'b1, 1'b1, 1'b1);
    mem[0] = 32'h0; mem[1] = 32'h425AA500;
    mem[15'h0010] = 32'h11112222; mem[15'h0020] = 32'h33334444; mem[15'h0030] = 32'h55556666;
    @(posedge clk); #1;

    // Round-robin with all four held from reset release
    step(-1); step(-1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(k % 4);
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0);
    step(-1);

    // Host write, then plain host read of a preloaded word
    host_addr = 17'h00002; host_wrdata = 8'hA5; host_write = 1'b1; host_req = 1'b1;
    step(0);
    host_req = 1'b0; step(-1);
    host_addr = 17'h00007; host_write = 1'b0; host_req = 1'b1;
    step(0);
    host_req = 1'b0; step(-1);
    chk("host_rd_0x42", 32'(host_rddata), 32'h42);

    // Write then read of the same word on consecutive grants
    host_addr = 17'h00005; host_wrdata = 8'h3C; host_write = 1'b1; host_req = 1'b1;
    step(0);
    host_write = 1'b0; step(0);
    host_req = 1'b0; step(-1);
    chk("host_wr_rd", 32'(host_rddata), 32'h3C);

    // Reset right after an l1 read grant
    l1_req = 1'b1; step(2);
    rst = 1'b1; set_reqs(1'b1, 1'b1, 1'b1, 1'b1); step(-1);
    rst = 1'b0; step(0); step(1);
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0); step(-1);

    // Abandoned l0 request while host wins
    rst = 1'b1; step(-1);
    rst = 1'b0; set_reqs(1'b1, 1'b1, 1'b0, 1'b0); step(0);
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0); step(-1);
    set_reqs(1'b1, 1'b1, 1'b1, 1'b1); step(1); step(2);
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0); step(-1);

    // Host priority instance: l0 and spr held, host every third cycle
    rst = 1'b1; step(-1);
    rst = 1'b0; prev_hp = -1;
    for (int k = 0; k < 12; k++) begin
      set_reqs(k % 3 == 0, 1'b1, 1'b0, 1'b1);
      exp_hp = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 1 : 3);
      #4;
      chk("hp_ack", 32'({hp_spr_ack, hp_l1_ack, hp_l0_ack, hp_host_ack}), 32'(1) << exp_hp);
      chk("hp_valid",
          32'({hp_spr_rddata_valid, hp_l1_rddata_valid, hp_l0_rddata_valid, hp_host_rddata_valid}),
          (prev_hp < 0) ? 32'h0 : 32'(1) << prev_hp);
      prev_hp = exp_hp;
      @(posedge clk); #1;
    end
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
